// File: rtl/pc_predict_unit_pkg.sv
// Shared constants for the fetch PC / branch predictor slice.
// Branch-op encodings, instruction step and counter seed values.
package pc_predict_unit_pkg;

  typedef enum logic [1:0] {
    BROP_EQZ = 2'b00,
    BROP_NEZ = 2'b01,
    BROP_LTZ = 2'b10,
    BROP_GEZ = 2'b11
  } brop_e;

  localparam int INSTR_BYTES = 2;

  // Seed values for the default 2-bit counters.
  localparam int CTR_WNT = 1;
  localparam int CTR_WT  = 2;

  // Same seeds for any counter width.
  function automatic int ctr_wnt(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int ctr_wt(input int bits);
    return 1 << (bits - 1);
  endfunction

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder built from four 4-bit groups.
// Ports: a_i, b_i, c_i in; s_o sum, c_o carry out.
module cla_16b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] s_o,
  output logic        c_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  pg;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign pg[k] = &p[4*k +: 4];
    assign gg[k] = g[4*k+3]
                 | (p[4*k+3] & g[4*k+2])
                 | (&p[4*k+2 +: 2] & g[4*k+1])
                 | (&p[4*k+1 +: 3] & g[4*k]);
  end

  always_comb begin
    logic [4:0]  gc;
    logic [15:0] c;
    gc    = '0;
    c     = '0;
    gc[0] = c_i;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
      gc[k+1] = gg[k] | (pg[k] & gc[k]);
    end
    s_o = p ^ c;
    c_o = gc[4];
  end

endmodule

// File: rtl/pc_predict_unit_sat_counter.sv
// Saturating up/down counter, one per BTB entry.
// Ports: clk, rst, inc_i, dec_i, load_i, load_val_i in; cnt_o out.
module sat_counter #(
  parameter int                   CTR_BITS = 2,
  parameter logic [CTR_BITS-1:0]  RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic                load_i,
  input  logic [CTR_BITS-1:0] load_val_i,
  output logic [CTR_BITS-1:0] cnt_o
);

  logic [CTR_BITS-1:0] cnt_q;
  logic [CTR_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with direct-mapped BTB prediction and execute-stage
// branch/jump resolution. Ports: fetch pc/prediction out, ex_* resolve in,
// branch_take/redirect/redirect_pc/err out.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               BTB_ENTRIES = 8,
  parameter int               CTR_BITS    = 2,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_reg_jump,
  input  logic [1:0]       ex_brop,
  input  logic             ex_zero,
  input  logic             ex_ltz,
  input  logic [WIDTH-1:0] ex_pc_inc,
  input  logic [WIDTH-1:0] ex_imm,
  input  logic [WIDTH-1:0] ex_jdist,
  input  logic [WIDTH-1:0] ex_reg,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  output logic             branch_take,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             err
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = WIDTH - IDX - 1;
  localparam logic [WIDTH-1:0]    STEP  = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-2:0]    HSTEP = (WIDTH-1)'(INSTR_BYTES / 2);
  localparam logic [CTR_BITS-1:0] C_RST = CTR_BITS'(ctr_wnt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] C_BR  = CTR_BITS'(ctr_wt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] C_J   = '1;

  logic [WIDTH-1:0]       pc_q, pc_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]        tag_q [BTB_ENTRIES];
  logic [TAGW-1:0]        tag_d [BTB_ENTRIES];
  logic [WIDTH-1:0]       tgt_q [BTB_ENTRIES];
  logic [WIDTH-1:0]       tgt_d [BTB_ENTRIES];
  logic [CTR_BITS-1:0]    ctr   [BTB_ENTRIES];

  // Fetch-side lookup
  logic [IDX-1:0]  l_idx;
  logic [TAGW-1:0] l_tag;
  logic            l_hit;

  assign l_idx       = pc_q[IDX:1];
  assign l_tag       = pc_q[WIDTH-1:IDX+1];
  assign l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = l_hit && ctr[l_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? tgt_q[l_idx] : pc_q + STEP;
  assign pc          = pc_q;

  // Target adders
  logic [WIDTH-1:0] br_tgt, j_base, j_tgt, actual;
  logic             br_co, j_co, j_ovf;

  assign j_base = ex_reg_jump ? ex_reg : ex_pc_inc;

  if (WIDTH == 16) begin : g_cla
    cla_16b u_br (
      .a_i(ex_pc_inc), .b_i(ex_imm), .c_i(1'b0),
      .s_o(br_tgt), .c_o(br_co)
    );
    cla_16b u_j (
      .a_i(j_base), .b_i(ex_jdist), .c_i(1'b0),
      .s_o(j_tgt), .c_o(j_co)
    );
  end else begin : g_add
    assign {br_co, br_tgt} = {1'b0, ex_pc_inc} + {1'b0, ex_imm};
    assign {j_co, j_tgt}   = {1'b0, j_base} + {1'b0, ex_jdist};
  end

  // Signed overflow: carry into MSB differs from carry out of MSB.
  assign j_ovf = j_co ^ j_base[WIDTH-1] ^ ex_jdist[WIDTH-1] ^ j_tgt[WIDTH-1];

  // Resolve
  logic cond, res, taken, alias_hit;

  always_comb begin
    cond = 1'b0;
    unique case (ex_brop)
      BROP_EQZ: cond = ex_zero;
      BROP_NEZ: cond = ~ex_zero;
      BROP_LTZ: cond = ex_ltz;
      BROP_GEZ: cond = ~ex_ltz;
    endcase
  end

  assign res       = ex_valid && (ex_branch || ex_jump);
  assign alias_hit = ex_valid && !(ex_branch || ex_jump) && ex_pred_taken;
  assign taken     = ex_jump || (ex_branch && cond);
  assign actual    = ex_jump ? j_tgt : br_tgt;

  always_comb begin
    branch_take = 1'b0;
    redirect    = 1'b0;
    redirect_pc = ex_pc_inc;
    err         = 1'b0;
    if (res) begin
      branch_take = taken;
      redirect    = (taken != ex_pred_taken)
                  || (taken && (actual != ex_pred_target));
      redirect_pc = taken ? actual : ex_pc_inc;
      err         = ex_jump ? j_ovf : br_co;
    end else if (alias_hit) begin
      redirect = 1'b1;
    end
  end

  // BTB update, indexed by the execute instruction's own PC
  logic [WIDTH-2:0] u_pc;
  logic [IDX-1:0]   u_idx;
  logic [TAGW-1:0]  u_tag;
  logic             u_hit;

  assign u_pc  = ex_pc_inc[WIDTH-1:1] - HSTEP;
  assign u_idx = u_pc[IDX-1:0];
  assign u_tag = u_pc[WIDTH-2:IDX];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  logic [BTB_ENTRIES-1:0] c_inc, c_dec, c_ld;
  logic [CTR_BITS-1:0]    c_ld_val;

  assign c_ld_val = ex_jump ? C_J : C_BR;

  always_comb begin
    c_inc   = '0;
    c_dec   = '0;
    c_ld    = '0;
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (res) begin
      if (u_hit) begin
        c_inc[u_idx] = taken;
        c_dec[u_idx] = ~taken;
      end else begin
        c_ld[u_idx]  = taken;
      end
      if (taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = actual;
      end
    end else if (alias_hit) begin
      valid_d[u_idx] = 1'b0;
    end
  end

  for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_ctr
    sat_counter #(
      .CTR_BITS(CTR_BITS),
      .RST_VAL (C_RST)
    ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (c_inc[i]),
      .dec_i     (c_dec[i]),
      .load_i    (c_ld[i]),
      .load_val_i(c_ld_val),
      .cnt_o     (ctr[i])
    );
  end

  // PC next state: redirect beats stall
  always_comb begin
    pc_d = pred_target;
    if (redirect)   pc_d = redirect_pc;
    else if (stall) pc_d = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit.
// Linear stimulus with immediate-assertion checks.
module tb_pc_predict_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [15:0] pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_reg_jump;
  logic [1:0]  ex_brop;
  logic        ex_zero;
  logic        ex_ltz;
  logic [15:0] ex_pc_inc;
  logic [15:0] ex_imm;
  logic [15:0] ex_jdist;
  logic [15:0] ex_reg;
  logic        ex_pred_taken;
  logic [15:0] ex_pred_target;
  logic        branch_take;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        err;

  int errors = 0;
  int checks = 0;

  pc_predict_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc            (pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump),
    .ex_reg_jump   (ex_reg_jump),
    .ex_brop       (ex_brop),
    .ex_zero       (ex_zero),
    .ex_ltz        (ex_ltz),
    .ex_pc_inc     (ex_pc_inc),
    .ex_imm        (ex_imm),
    .ex_jdist      (ex_jdist),
    .ex_reg        (ex_reg),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .branch_take   (branch_take),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic idle();
    ex_valid       = 1'b0;
    ex_branch      = 1'b0;
    ex_jump        = 1'b0;
    ex_reg_jump    = 1'b0;
    ex_brop        = 2'b00;
    ex_zero        = 1'b0;
    ex_ltz         = 1'b0;
    ex_pc_inc      = 16'h0;
    ex_imm         = 16'h0;
    ex_jdist       = 16'h0;
    ex_reg         = 16'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 16'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-control instruction flagged predicted-taken: steers pc to addr.
  // Side effect: invalidates the BTB entry of addr-2.
  task automatic goto(input logic [15:0] addr);
    idle();
    ex_valid      = 1'b1;
    ex_pred_taken = 1'b1;
    ex_pc_inc     = addr;
    tick();
    idle();
  endtask

  task automatic br(input logic [15:0] pinc, input logic [15:0] imm,
                    input logic [1:0] op, input logic z, input logic l,
                    input logic pt, input logic [15:0] ptgt);
    idle();
    ex_valid       = 1'b1;
    ex_branch      = 1'b1;
    ex_brop        = op;
    ex_zero        = z;
    ex_ltz         = l;
    ex_pc_inc      = pinc;
    ex_imm         = imm;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  initial begin
    rst   = 1'b0;
    stall = 1'b1;
    idle();

    // Reset mid-cycle, no clock edge yet
    #2 rst = 1'b1;
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_pred_taken", 16'(pred_taken), 16'h0);
    chk("rst_pred_target", pred_target, 16'h0002);
    chk("rst_redirect", 16'(redirect), 16'h0);
    tick();
    tick();
    rst = 1'b0;

    // BEQZ at 0x0010 taken, BTB miss
    br(16'h0012, 16'h0020, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0012);
    #1;
    chk("beqz_redirect", 16'(redirect), 16'h1);
    chk("beqz_redirect_pc", redirect_pc, 16'h0032);
    chk("beqz_take", 16'(branch_take), 16'h1);
    chk("beqz_err", 16'(err), 16'h0);
    tick();
    chk("beqz_pc", pc, 16'h0032);
    goto(16'h0010);
    chk("goto_pc", pc, 16'h0010);
    chk("alloc_pred_taken", 16'(pred_taken), 16'h1);
    chk("alloc_pred_target", pred_target, 16'h0032);
    stall = 1'b0;
    tick();
    chk("follow_pred_pc", pc, 16'h0032);
    stall = 1'b1;

    // Counter saturation: three correctly predicted takens
    for (int i = 0; i < 3; i++) begin
      br(16'h0012, 16'h0020, 2'b00, 1'b1, 1'b0, 1'b1, 16'h0032);
      #1;
      chk("sat_taken_redirect", 16'(redirect), 16'h0);
      tick();
    end
    br(16'h0012, 16'h0020, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0032);
    #1;
    chk("nt1_take", 16'(branch_take), 16'h0);
    chk("nt1_redirect", 16'(redirect), 16'h1);
    chk("nt1_redirect_pc", redirect_pc, 16'h0012);
    tick();
    goto(16'h0010);
    chk("nt1_still_taken", 16'(pred_taken), 16'h1);
    br(16'h0012, 16'h0020, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0032);
    tick();
    goto(16'h0010);
    chk("nt2_pred_taken", 16'(pred_taken), 16'h0);
    chk("nt2_pred_target", pred_target, 16'h0012);
    br(16'h0012, 16'h0020, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0012);
    #1;
    chk("retrain_redirect", 16'(redirect), 16'h1);
    tick();
    goto(16'h0010);
    chk("retrain_pred_taken", 16'(pred_taken), 16'h1);

    // Alias: non-branch at 0x0020 predicted taken
    idle();
    ex_valid      = 1'b1;
    ex_pred_taken = 1'b1;
    ex_pred_target = 16'h0032;
    ex_pc_inc     = 16'h0022;
    #1;
    chk("alias_redirect", 16'(redirect), 16'h1);
    chk("alias_redirect_pc", redirect_pc, 16'h0022);
    chk("alias_take", 16'(branch_take), 16'h0);
    tick();
    chk("alias_pc", pc, 16'h0022);
    goto(16'h0010);
    chk("alias_inval", 16'(pred_taken), 16'h0);

    // Miss and not taken: no allocation
    br(16'h0012, 16'h0020, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0012);
    #1;
    chk("miss_nt_redirect", 16'(redirect), 16'h0);
    chk("miss_nt_redirect_pc", redirect_pc, 16'h0012);
    tick();
    goto(16'h0010);
    chk("miss_nt_noalloc", 16'(pred_taken), 16'h0);

    // JALR with signed overflow
    idle();
    ex_valid    = 1'b1;
    ex_jump     = 1'b1;
    ex_reg_jump = 1'b1;
    ex_reg      = 16'h7FFE;
    ex_jdist    = 16'h0004;
    ex_pc_inc   = 16'h0040;
    #1;
    chk("jalr_err", 16'(err), 16'h1);
    chk("jalr_redirect_pc", redirect_pc, 16'h8002);
    chk("jalr_take", 16'(branch_take), 16'h1);
    chk("jalr_redirect", 16'(redirect), 16'h1);
    tick();
    chk("jalr_pc", pc, 16'h8002);
    goto(16'h003E);
    chk("jalr_pred_taken", 16'(pred_taken), 16'h1);
    chk("jalr_pred_target", pred_target, 16'h8002);
    // Jump allocated strong-taken: one not-taken still predicts taken
    br(16'h0040, 16'h0020, 2'b00, 1'b0, 1'b0, 1'b1, 16'h8002);
    #1;
    chk("jctr_nt_redirect_pc", redirect_pc, 16'h0040);
    tick();
    goto(16'h003E);
    chk("jctr_strong", 16'(pred_taken), 16'h1);

    // BNEZ with zero=1, predicted not taken
    br(16'h0050, 16'h0020, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0050);
    #1;
    chk("bnez_redirect", 16'(redirect), 16'h0);
    chk("bnez_take", 16'(branch_take), 16'h0);
    chk("bnez_err", 16'(err), 16'h0);
    tick();

    // JAL, base is ex_pc_inc, backward, correctly predicted
    idle();
    ex_valid       = 1'b1;
    ex_jump        = 1'b1;
    ex_reg         = 16'h7FFE;
    ex_jdist       = 16'hFFFC;
    ex_pc_inc      = 16'h0100;
    ex_pred_taken  = 1'b1;
    ex_pred_target = 16'h00FC;
    #1;
    chk("jal_redirect", 16'(redirect), 16'h0);
    chk("jal_redirect_pc", redirect_pc, 16'h00FC);
    chk("jal_err", 16'(err), 16'h0);
    tick();

    // BLTZ backward: unsigned carry-out raises err
    br(16'h0050, 16'hFFF0, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0050);
    #1;
    chk("bltz_take", 16'(branch_take), 16'h1);
    chk("bltz_redirect_pc", redirect_pc, 16'h0040);
    chk("bltz_err", 16'(err), 16'h1);
    tick();
    br(16'h0050, 16'h0020, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0050);
    #1;
    chk("bgez_take", 16'(branch_take), 16'h0);
    chk("bgez_redirect", 16'(redirect), 16'h0);
    tick();

    // Redirect overrides stall, then stall holds
    stall = 1'b1;
    goto(16'h0200);
    chk("stall_redirect_pc", pc, 16'h0200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", pc, 16'h0200);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc", pc, 16'h0202);
    stall = 1'b1;

    // Reset during a pending allocation
    br(16'h0012, 16'h0020, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0012);
    #1 rst = 1'b1;
    #1;
    chk("rst2_pc", pc, 16'h0000);
    tick();
    rst = 1'b0;
    goto(16'h0010);
    chk("rst2_lost_update", 16'(pred_taken), 16'h0);
    chk("rst2_pred_target", pred_target, 16'h0012);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
